// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_pkg
//  Brief    : Shared op/state encodings and helpers for the multiply/divide unit.
//  Revision : 1.0  initial release
// ============================================================================
package muldiv_pkg;

    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_e;

    // Magnitude of a two's-complement operand; unsigned ops pass through.
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit_if
//  Brief    : Request/response bundle between a pipeline and the muldiv unit.
//  Revision : 1.0  initial release
// ============================================================================
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi_en;
    logic        mtlo_en;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, a, b, mthi_en, mtlo_en, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi_en, mtlo_en, wdata,
        output busy, done, hi, lo
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Brief    : Iterative 32x32 multiply / 32/32 divide with HI/LO result regs.
//  Revision : 1.0  initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
(
    input  wire logic     clk,
    input  wire logic     reset_n,
    muldiv_unit_if.slave  bus
);

    localparam logic [4:0] c_last_iter = 5'(MD_ITER - 1);

    md_state_e   r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_mcand;
    logic        r_neg_q;
    logic        r_neg_r;
    logic        r_bzero;
    logic        r_is_div;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;

    logic        w_signed;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [32:0] w_add;
    logic [32:0] w_sub;
    logic [63:0] w_prod;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    assign w_signed = (md_op_e'(bus.op) == OP_MULT) || (md_op_e'(bus.op) == OP_DIV);
    assign w_a_mag  = md_mag(bus.a, w_signed);
    assign w_b_mag  = md_mag(bus.b, w_signed);

    // Both ops keep {upper, lower} in r_acc: product/multiplier for MUL,
    // remainder/quotient for DIV, so one load path serves both.
    assign w_add  = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_mcand : 32'd0)};
    assign w_sub  = r_acc[63:31] - {1'b0, r_mcand};

    assign w_prod = r_neg_q ? (~r_acc + 64'd1) : r_acc;
    assign w_quo  = r_bzero ? 32'hFFFF_FFFF
                            : (r_neg_q ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
    assign w_rem  = r_neg_r ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_bzero  <= 1'b0;
            r_is_div <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.mthi_en) r_hi <= bus.wdata;
                    if (bus.mtlo_en) r_lo <= bus.wdata;
                    if (bus.start) begin
                        r_state  <= bus.op[1] ? ST_DIV : ST_MUL;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_acc    <= {32'd0, w_a_mag};
                        r_mcand  <= w_b_mag;
                        r_is_div <= bus.op[1];
                        r_bzero  <= bus.op[1] && (bus.b == 32'd0);
                        r_neg_q  <= w_signed && (bus.a[31] ^ bus.b[31]);
                        r_neg_r  <= w_signed && bus.op[1] && bus.a[31];
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (r_state == ST_MUL)
                        r_acc <= {w_add, r_acc[31:1]};
                    else if (w_sub[32])
                        r_acc <= {r_acc[62:0], 1'b0};
                    else
                        r_acc <= {w_sub[31:0], r_acc[30:0], 1'b1};
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == c_last_iter) r_state <= ST_FIX;
                end
                ST_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[63:32];
                        r_lo <= w_prod[31:0];
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port start, input, 1, request strobe; sampled only in IDLE.
REQ-004 SHALL have port op, input, 2, operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-005 SHALL have ports a and b, input, 32 each; a is multiplicand/dividend, b is multiplier/divisor.
REQ-006 SHALL have ports mthi_en and mtlo_en, input, 1 each; write wdata into HI/LO.
REQ-007 SHALL have port wdata, input, 32, MTHI/MTLO data.
REQ-008 SHALL have port busy, output, 1; high while an operation is in flight.
REQ-009 SHALL have port done, output, 1; one-cycle completion pulse.
REQ-010 SHALL have ports hi and lo, output, 32 each; registered HI/LO contents (MFHI/MFLO source).

Function
REQ-011 SHALL implement FSM states IDLE, MUL, DIV, FIX.
- IDLE to MUL (op 0x) or DIV (op 1x) on start.
- MUL/DIV to FIX after 32 iterations.
- FIX to IDLE unconditionally.
REQ-012 SHALL, on accept edge E0, latch operand magnitudes, result signs and op; later changes on a/b/op have no effect.
REQ-013 SHALL perform one iteration per edge E1..E32:
- MUL: radix-2 shift-add on 64-bit product.
- DIV: restoring shift-subtract, 32-bit quotient and remainder.
REQ-014 SHALL at E33 (FIX) apply sign correction and write hi/lo; total latency 33 clocks from accept edge.
REQ-015 SHALL drive busy=1 from E0 through E33 exclusive of the cycle after E33, i.e. busy high in MUL, DIV and FIX states.
REQ-016 SHALL drive done=1 for exactly the one cycle following E33, coincident with the new hi/lo values.
REQ-017 SHALL produce the full 64-bit product for MULT/MULTU: {hi,lo}; MULT treats a, b as two's complement.
REQ-018 SHALL produce lo=quotient, hi=remainder for DIV/DIVU; signed quotient truncates toward zero, remainder takes the dividend's sign.
REQ-019 SHALL, for DIV of 0x80000000 by 0xFFFFFFFF, give lo=0x80000000, hi=0.
REQ-020 SHALL, for b==0 on DIV or DIVU, give hi=a and lo=0xFFFFFFFF after the normal 33-clock latency.
REQ-021 SHALL ignore start while busy; no queuing.
REQ-022 SHALL apply mthi_en/mtlo_en only in IDLE, at the sampling edge; ignored while busy.
REQ-023 SHALL, when start and mthi_en/mtlo_en coincide in IDLE, apply the move at E0; the operation result overwrites hi and lo at E33.
REQ-024 SHALL hold hi/lo stable except at MTHI/MTLO writes and FIX.

Reset
REQ-025 SHALL on reset_n low, immediately and regardless of state:
- enter IDLE
- clear hi, lo, busy, done and all iteration registers to 0
REQ-026 SHALL abandon an in-flight operation on mid-operation reset with no done pulse, and accept start on the first edge after reset_n rises.

Structure
REQ-027 SHALL place in shared package muldiv_pkg:
- op encoding enum
- FSM state enum
- constant MD_ITER=32
REQ-028 SHALL be a single module; sign handling and iteration datapath are small enough that no sub-module is natural.

Verification
REQ-029 SHALL cover MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001, done exactly 33 clocks after accept.
REQ-030 SHALL cover MULT a=0xFFFFFFFD (-3), b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
REQ-031 SHALL cover signed division cases:
- DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0
REQ-032 SHALL cover DIVU a=0x12345678, b=0 -> hi=0x12345678, lo=0xFFFFFFFF.
REQ-033 SHALL cover handshake rules:
- second start at E5 of a busy op -> ignored, single done
- mthi_en with wdata=0xAAAA5555 in IDLE -> hi=0xAAAA5555, lo unchanged
REQ-034 SHALL cover reset_n pulsed low at E10 of a DIV -> hi=lo=0, busy=0, no done; fresh MULTU 3*4 afterwards -> lo=12, hi=0.
